// File: rtl/ex_stage.sv
// Execute stage of a single-cycle MIPS-style datapath: ALU, shifter, mult/div
// with HI/LO registers, and next-PC selection for jumps and branches.
module ex_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic [31:0] Rdata1,
    input  logic [31:0] Rdata2,
    input  logic [31:0] Ed32,
    input  logic [31:0] nextPC,
    output logic [31:0] Result,
    output logic [31:0] newPC
);

    // Returns {remainder, quotient}; covers the two cases the native operators leave undefined.
    function automatic logic [63:0] divide(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [4:0]         rt;
    logic [31:0]        hi_q, lo_q, hi_d, lo_d;
    logic [31:0]        pc4, br_target, j_target;
    logic signed [31:0] a_s, b_s, imm_s;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u, div_s, div_u;
    logic               br_taken;

    assign opcode    = Ins[31:26];
    assign funct     = Ins[5:0];
    assign rt        = Ins[20:16];
    assign a_s       = Rdata1;
    assign b_s       = Rdata2;
    assign imm_s     = Ed32;
    assign pc4       = nextPC + 32'd4;
    assign br_target = nextPC + {Ed32[29:0], 2'b00};
    assign j_target  = {nextPC[31:28], Ins[25:0], 2'b00};
    assign prod_s    = $signed({{32{Rdata1[31]}}, Rdata1}) * $signed({{32{Rdata2[31]}}, Rdata2});
    assign prod_u    = {32'h0, Rdata1} * {32'h0, Rdata2};
    assign div_s     = divide(Rdata1, Rdata2, 1'b1);
    assign div_u     = divide(Rdata1, Rdata2, 1'b0);

    always_comb begin
        Result   = 32'h0;
        newPC    = pc4;
        hi_d     = hi_q;
        lo_d     = lo_q;
        br_taken = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21: Result = Rdata1 + Rdata2;
                    6'h22, 6'h23: Result = Rdata1 - Rdata2;
                    6'h24: Result = Rdata1 & Rdata2;
                    6'h25: Result = Rdata1 | Rdata2;
                    6'h26: Result = Rdata1 ^ Rdata2;
                    6'h27: Result = ~(Rdata1 | Rdata2);
                    6'h2A: Result = {31'h0, a_s < b_s};
                    6'h2B: Result = {31'h0, Rdata1 < Rdata2};
                    6'h00: Result = Rdata2 << Ed32[4:0];
                    6'h02: Result = Rdata2 >> Ed32[4:0];
                    6'h03: Result = b_s >>> Ed32[4:0];
                    6'h04: Result = Rdata2 << Rdata1[4:0];
                    6'h06: Result = Rdata2 >> Rdata1[4:0];
                    6'h07: Result = b_s >>> Rdata1[4:0];
                    6'h18: begin
                        Result = prod_s[31:0];
                        hi_d   = prod_s[63:32];
                        lo_d   = prod_s[31:0];
                    end
                    6'h19: begin
                        Result = prod_u[31:0];
                        hi_d   = prod_u[63:32];
                        lo_d   = prod_u[31:0];
                    end
                    6'h1A: begin
                        Result = div_s[31:0];
                        hi_d   = div_s[63:32];
                        lo_d   = div_s[31:0];
                    end
                    6'h1B: begin
                        Result = div_u[31:0];
                        hi_d   = div_u[63:32];
                        lo_d   = div_u[31:0];
                    end
                    6'h10: Result = hi_q;
                    6'h12: Result = lo_q;
                    6'h11: hi_d = Rdata1;
                    6'h13: lo_d = Rdata1;
                    6'h08: newPC = Rdata1;
                    6'h09: begin
                        newPC  = Rdata1;
                        Result = pc4;
                    end
                    default: ;
                endcase
            end
            // REGIMM: the link variants write the return address even when not taken.
            6'h01: begin
                case (rt)
                    5'h00: br_taken = a_s < 0;
                    5'h01: br_taken = a_s >= 0;
                    5'h10: begin
                        br_taken = a_s < 0;
                        Result   = pc4;
                    end
                    5'h11: begin
                        br_taken = a_s >= 0;
                        Result   = pc4;
                    end
                    default: ;
                endcase
            end
            6'h02: newPC = j_target;
            6'h03: begin
                newPC  = j_target;
                Result = pc4;
            end
            6'h04: br_taken = Rdata1 == Rdata2;
            6'h05: br_taken = Rdata1 != Rdata2;
            6'h06: br_taken = a_s <= 0;
            6'h07: br_taken = a_s > 0;
            6'h08, 6'h09: Result = Rdata1 + Ed32;
            6'h0A: Result = {31'h0, a_s < imm_s};
            6'h0B: Result = {31'h0, Rdata1 < Ed32};
            6'h0C: Result = Rdata1 & Ed32;
            6'h0D: Result = Rdata1 | Ed32;
            6'h0E: Result = Rdata1 ^ Ed32;
            6'h0F: Result = {Ed32[15:0], 16'h0000};
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
            6'h28, 6'h29, 6'h2A, 6'h2B: Result = Rdata1 + Ed32;
            default: ;
        endcase
        if (br_taken) newPC = br_target;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hi_q <= 32'h0;
            lo_q <= 32'h0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed scenarios plus randomized instructions
// compared against an arithmetic reference model that tracks HI/LO.
module tb_ex_stage;

    logic        CLK;
    logic        RST;
    logic [31:0] Ins, Rdata1, Rdata2, Ed32, nextPC;
    logic [31:0] Result, newPC;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;
    logic [31:0] u_res, u_pc, u_hi, u_lo;

    ex_stage dut (
        .CLK    (CLK),
        .RST    (RST),
        .Ins    (Ins),
        .Rdata1 (Rdata1),
        .Rdata2 (Rdata2),
        .Ed32   (Ed32),
        .nextPC (nextPC),
        .Result (Result),
        .newPC  (newPC)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: instruction semantics written with 64-bit integer arithmetic.
    function automatic void ref_model(input logic [31:0] ins, r1, r2, ed, npc, hi, lo,
                                      output logic [31:0] res, pc, hn, ln);
        logic [5:0]  op, fn;
        logic [4:0]  rtf;
        longint      sa, sb;
        logic [63:0] p;
        logic [31:0] tgt;
        logic        take;
        op   = ins[31:26];
        fn   = ins[5:0];
        rtf  = ins[20:16];
        res  = 0;
        pc   = npc + 4;
        hn   = hi;
        ln   = lo;
        take = 0;
        tgt  = npc + ed * 4;
        sa   = longint'(int'(r1));
        sb   = longint'(int'(r2));
        if (op == 0) begin
            case (fn)
                6'h20, 6'h21: res = r1 + r2;
                6'h22, 6'h23: res = r1 - r2;
                6'h24: res = r1 & r2;
                6'h25: res = r1 | r2;
                6'h26: res = r1 ^ r2;
                6'h27: res = ~(r1 | r2);
                6'h2A: res = (sa < sb) ? 1 : 0;
                6'h2B: res = (r1 < r2) ? 1 : 0;
                6'h00: res = r2 * (32'd1 << ed[4:0]);
                6'h02: res = r2 / (32'd1 << ed[4:0]);
                6'h03: begin p = 64'(sb >>> ed[4:0]); res = p[31:0]; end
                6'h04: res = r2 * (32'd1 << r1[4:0]);
                6'h06: res = r2 / (32'd1 << r1[4:0]);
                6'h07: begin p = 64'(sb >>> r1[4:0]); res = p[31:0]; end
                6'h18: begin p = sa * sb; res = p[31:0]; hn = p[63:32]; ln = p[31:0]; end
                6'h19: begin p = {32'h0, r1} * {32'h0, r2}; res = p[31:0]; hn = p[63:32]; ln = p[31:0]; end
                6'h1A: begin
                    if (r2 == 0) begin ln = 32'hFFFFFFFF; hn = r1; end
                    else begin p = 64'(sa / sb); ln = p[31:0]; p = 64'(sa % sb); hn = p[31:0]; end
                    res = ln;
                end
                6'h1B: begin
                    if (r2 == 0) begin ln = 32'hFFFFFFFF; hn = r1; end
                    else begin ln = r1 / r2; hn = r1 % r2; end
                    res = ln;
                end
                6'h10: res = hi;
                6'h12: res = lo;
                6'h11: hn = r1;
                6'h13: ln = r1;
                6'h08: pc = r1;
                6'h09: begin pc = r1; res = npc + 4; end
                default: ;
            endcase
        end else if (op == 6'h01) begin
            if (rtf == 5'h00 || rtf == 5'h10) take = sa < 0;
            if (rtf == 5'h01 || rtf == 5'h11) take = sa >= 0;
            if (rtf == 5'h10 || rtf == 5'h11) res = npc + 4;
        end else begin
            case (op)
                6'h02: pc = {npc[31:28], ins[25:0], 2'b00};
                6'h03: begin pc = {npc[31:28], ins[25:0], 2'b00}; res = npc + 4; end
                6'h04: take = r1 == r2;
                6'h05: take = r1 != r2;
                6'h06: take = sa <= 0;
                6'h07: take = sa > 0;
                6'h08, 6'h09: res = r1 + ed;
                6'h0A: res = (int'(r1) < int'(ed)) ? 1 : 0;
                6'h0B: res = (r1 < ed) ? 1 : 0;
                6'h0C: res = r1 & ed;
                6'h0D: res = r1 | ed;
                6'h0E: res = r1 ^ ed;
                6'h0F: res = ed * 65536;
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                6'h28, 6'h29, 6'h2A, 6'h2B: res = r1 + ed;
                default: ;
            endcase
        end
        if (take) pc = tgt;
    endfunction

    // HI/LO of the model advance on the same edge as the design.
    always @(posedge CLK) begin
        ref_model(Ins, Rdata1, Rdata2, Ed32, nextPC, m_hi, m_lo, u_res, u_pc, u_hi, u_lo);
        if (RST) begin
            m_hi <= 32'h0;
            m_lo <= 32'h0;
        end else begin
            m_hi <= u_hi;
            m_lo <= u_lo;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, r1, r2, ed, npc, input logic rst,
                         input string tag);
        logic [31:0] er, ep, eh, el;
        @(negedge CLK);
        Ins = ins; Rdata1 = r1; Rdata2 = r2; Ed32 = ed; nextPC = npc; RST = rst;
        #1;
        ref_model(ins, r1, r2, ed, npc, m_hi, m_lo, er, ep, eh, el);
        check({tag, "/Result"}, Result, er);
        check({tag, "/newPC"}, newPC, ep);
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = $urandom_range(0, 20);
            4: v = 32'h0 - $urandom_range(1, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    logic [5:0] rfun [0:27] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13,
                                6'h08, 6'h09, 6'h01, 6'h3F};
    logic [5:0] rops [0:26] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                                6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21,
                                6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h28, 6'h29, 6'h2A,
                                6'h2B, 6'h27, 6'h3F};
    logic [4:0] rrt  [0:4]  = '{5'h00, 5'h01, 5'h10, 5'h11, 5'h05};

    initial begin
        logic [31:0] ins, r1, r2, ed, npc, h;
        Ins = 0; Rdata1 = 0; Rdata2 = 0; Ed32 = 0; nextPC = 0; RST = 1'b1;
        repeat (2) @(posedge CLK);

        drive(32'h0000_0020, 32'd1, 32'd2, 32'd0, 32'd0, 1'b1, "add_in_reset");
        check("add_in_reset_val", Result, 32'd3);
        drive(32'h0000_0010, 0, 0, 0, 0, 1'b0, "mfhi_reset");
        check("mfhi_reset_val", Result, 32'h0);
        drive(32'h0000_0012, 0, 0, 0, 0, 1'b0, "mflo_reset");
        check("mflo_reset_val", Result, 32'h0);

        drive(32'h0000_0027, 32'hF, 32'h3, 0, 0, 1'b0, "nor");
        check("nor_val", Result, 32'hFFFF_FFF0);
        drive(32'h0000_002A, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 0, 1'b0, "slt");
        check("slt_val", Result, 32'h0);
        drive(32'h0000_0003, 0, 32'hFFFF_FFF0, 32'd2, 0, 1'b0, "sra");
        check("sra_val", Result, 32'hFFFF_FFFC);
        drive(32'h0000_0004, 32'd2, 32'd3, 0, 0, 1'b0, "sllv");
        check("sllv_val", Result, 32'hC);

        drive(32'h0000_001A, 32'hF, 32'd3, 0, 0, 1'b0, "div");
        check("div_val", Result, 32'd5);
        drive(32'h0000_0010, 0, 0, 0, 0, 1'b0, "div_mfhi");
        check("div_mfhi_val", Result, 32'h0);
        drive(32'h0000_0018, 32'd5, 32'd3, 0, 0, 1'b0, "mult");
        check("mult_val", Result, 32'hF);
        drive(32'h0000_0020, 32'd7, 32'd7, 0, 0, 1'b0, "hold_add");
        drive(32'h0000_0012, 0, 0, 0, 0, 1'b0, "mult_mflo");
        check("mult_mflo_val", Result, 32'hF);
        drive(32'h0000_0013, 32'h1234, 0, 0, 0, 1'b1, "mtlo_in_reset");
        drive(32'h0000_0012, 0, 0, 0, 0, 1'b0, "rst_mflo");
        check("rst_mflo_val", Result, 32'h0);

        drive(32'h0000_001A, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0, "div_ovf");
        check("div_ovf_q", Result, 32'h8000_0000);
        drive(32'h0000_001B, 32'h55, 32'h0, 0, 0, 1'b0, "divu_zero");
        check("divu_zero_q", Result, 32'hFFFF_FFFF);
        drive(32'h0000_0010, 0, 0, 0, 0, 1'b0, "divu_zero_mfhi");
        check("divu_zero_rem", Result, 32'h55);

        drive(32'h0000_0009, 32'h2000, 0, 0, 32'd8, 1'b0, "jalr");
        check("jalr_pc", newPC, 32'h2000);
        check("jalr_link", Result, 32'hC);
        drive(32'h0C00_0400, 0, 0, 0, 32'd8, 1'b0, "jal");
        check("jal_pc", newPC, 32'h1000);
        check("jal_link", Result, 32'hC);

        drive(32'h1000_0002, 32'd5, 32'd5, 32'd8, 32'd4, 1'b0, "beq_t");
        check("beq_taken_pc", newPC, 32'h24);
        drive(32'h1000_0002, 32'd5, 32'd3, 32'd8, 32'd4, 1'b0, "beq_nt");
        check("beq_not_taken_pc", newPC, 32'h8);
        drive(32'h0400_0002, 32'hFFFF_FFFF, 0, 32'd8, 32'd4, 1'b0, "bltz");
        check("bltz_pc", newPC, 32'h24);

        drive(32'h8C00_0004, 32'h1000, 0, 32'd4, 32'h40, 1'b0, "lw");
        check("lw_addr", Result, 32'h1004);
        check("lw_pc", newPC, 32'h44);

        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            case ($urandom_range(0, 3))
                0, 1: begin ins[31:26] = 6'h00; ins[5:0] = rfun[$urandom_range(0, 27)]; end
                2: begin ins[31:26] = 6'h01; ins[20:16] = rrt[$urandom_range(0, 4)]; end
                default: ins[31:26] = rops[$urandom_range(0, 26)];
            endcase
            r1 = rnd_val();
            r2 = ($urandom_range(0, 3) == 0) ? r1 : rnd_val();
            if ($urandom_range(0, 1) == 1) begin
                h  = $urandom;
                ed = {{16{h[15]}}, h[15:0]};
            end else begin
                ed = rnd_val();
            end
            npc = $urandom;
            npc[1:0] = 2'b00;
            drive(ins, r1, r2, ed, npc, ($urandom_range(0, 31) == 0), "rand");
        end

        drive(32'h0000_0010, 0, 0, 0, 0, 1'b0, "final_mfhi");
        drive(32'h0000_0012, 0, 0, 0, 0, 1'b0, "final_mflo");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 CLK  input  1  single clock; HI/LO registers update on rising edge.
REQ-002 RST  input  1  reset, synchronous and active-high.
REQ-003 Ins  input  32  instruction; opcode Ins[31:26], rt Ins[20:16], funct Ins[5:0], instr_index Ins[25:0].
REQ-004 Rdata1  input  32  rs operand.
REQ-005 Rdata2  input  32  rt operand.
REQ-006 Ed32  input  32  pre-extended immediate from decode; for R-type shifts, shamt = Ed32[4:0].
REQ-007 nextPC  input  32  PC+4 of the current instruction.
REQ-008 Result  output  32  ALU, link or move result; combinational.
REQ-009 newPC  output  32  next fetch address; combinational.

Function
REQ-010 Result and newPC SHALL be purely combinational from the inputs and HI/LO, and SHALL not be gated by RST.
REQ-011 newPC SHALL default to nextPC+4, which applies to all non-control instructions and not-taken branches.
REQ-012 The R-type instructions (opcode 0x00), selected by funct, SHALL produce the following Result:
- 0x20/0x21 add; 0x22/0x23 sub, 32-bit wrap, no overflow trap.
- 0x24 and; 0x25 or; 0x26 xor; 0x27 nor.
- 0x2A signed compare, 0x2B unsigned compare; Result is 1 if Rdata1 < Rdata2, else 0.
REQ-013 Shifts SHALL operate as follows:
- 0x00 SLL, 0x02 SRL, 0x03 SRA: shift Rdata2 by Ed32[4:0].
- 0x04 SLLV, 0x06 SRLV, 0x07 SRAV: shift Rdata2 by Rdata1[4:0].
- SRA/SRAV are arithmetic shifts.
REQ-014 Multiply and divide SHALL behave as follows:
- 0x18 MULT signed, 0x19 MULTU unsigned: Result = low 32 bits of the 64-bit product; on the CLK edge, HI = product[63:32] and LO = product[31:0].
- 0x1A DIV signed, 0x1B DIVU unsigned: Result = quotient; on the CLK edge, LO = quotient and HI = remainder.
- Signed division truncates toward zero; the remainder takes the dividend's sign.
REQ-015 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = Rdata1; signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-016 HI/LO moves SHALL behave as follows:
- 0x10 MFHI: Result = HI.
- 0x12 MFLO: Result = LO.
- 0x11 MTHI: HI <= Rdata1 on the edge, Result = 0.
- 0x13 MTLO: LO <= Rdata1 on the edge, Result = 0.
REQ-017 R-type jumps SHALL behave as follows:
- 0x08 JR: newPC = Rdata1, Result = 0.
- 0x09 JALR: newPC = Rdata1, Result = nextPC+4.
REQ-018 I-type instructions SHALL use Ed32 as the operand without re-extending it:
- 0x08/0x09: Rdata1+Ed32.
- 0x0A signed set-less-than, 0x0B unsigned set-less-than.
- 0x0C and, 0x0D or, 0x0E xor.
- 0x0F LUI: Result = {Ed32[15:0], 16'h0000}.
REQ-019 Loads and stores (opcodes 0x20-0x26, 0x28-0x2B) SHALL give Result = Rdata1+Ed32.
REQ-020 J (0x02) SHALL set newPC = {nextPC[31:28], Ins[25:0], 2'b00} and Result = 0; JAL (0x03) SHALL use the same newPC with Result = nextPC+4.
REQ-021 Branch target SHALL be nextPC + (Ed32 << 2) with 32-bit wrap, and Result = 0 for branches; conditions:
- 0x04 BEQ: Rdata1 == Rdata2.
- 0x05 BNE: Rdata1 != Rdata2.
- 0x06 BLEZ: signed Rdata1 <= 0.
- 0x07 BGTZ: signed Rdata1 > 0.
- 0x01 REGIMM, selected by rt: 0x00 BLTZ (< 0); 0x01 BGEZ (>= 0).
- REGIMM rt 0x10 BLTZAL and 0x11 BGEZAL use the same conditions and set Result = nextPC+4 whether or not the branch is taken.
REQ-022 Unlisted opcode/funct SHALL give Result = 0 and newPC = nextPC+4, and SHALL leave HI/LO unchanged.

Reset
REQ-023 While RST=1 at a CLK edge, HI and LO SHALL be set to 0, and this SHALL take priority over any mult/div/move write in the same cycle.
REQ-024 HI/LO SHALL hold their value on every edge not caused by a writing instruction.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- ALU: Ins=0x00000027, Rdata1=0xF, Rdata2=0x3 -> Result=0xFFFFFFF0; Ins=0x0000002A, Rdata1=0xFFFFFFFE, Rdata2=0xFFFFFFFD -> Result=0.
- Shift: Ins=0x00000003, Rdata2=0xFFFFFFF0, Ed32=2 -> Result=0xFFFFFFFC; Ins=0x00000004, Rdata1=2, Rdata2=3 -> Result=0xC.
- Mult/div: Ins=0x0000001A, Rdata1=0xF, Rdata2=3 -> Result=5, then MFHI after the edge -> Result=0; MULT 5*3 -> Result=0xF, then MFLO -> 0xF; RST edge then MFLO -> 0.
- Jumps: JALR Ins=0x00000009, Rdata1=0x2000, nextPC=8 -> newPC=0x2000, Result=0xC; JAL Ins=0x0C000400, nextPC=8 -> newPC=0x1000, Result=0xC.
- Branches: nextPC=4, Ed32=8; BEQ Ins=0x10000002 with 5/5 -> newPC=0x24, with 5/3 -> newPC=8; BLTZ Ins=0x04000002, Rdata1=0xFFFFFFFF -> newPC=0x24.
- Memory: Ins=0x8C000004, Rdata1=0x1000, Ed32=4 -> Result=0x1004, newPC=nextPC+4.
